// File: rtl/folded_fir_scheduler.sv
// folded_fir_scheduler: sequencer for a time-shared FIR MAC.
// Accepts one sample per valid/ready handshake, shifts it into an NTAPS-deep
// delay line and presents one (sample, coefficient) pair per clock to an
// external MAC, with first/last strobes framing each output sample.
// Optional feature: define COEF_SHADOW_EN for a double-buffered coefficient
// bank whose commits only take effect on a sample boundary.
module folded_fir_scheduler #(
  parameter int unsigned NTAPS = 5,
  parameter int unsigned DW    = 12,
  parameter int unsigned CW    = 13,
  parameter int unsigned AW    = 3
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 coef_we,
  input  logic        [AW-1:0] coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  input  logic                 coef_commit,
  output logic                 mac_valid,
  output logic signed [DW-1:0] mac_data,
  output logic signed [CW-1:0] mac_coef,
  output logic        [AW-1:0] mac_tap,
  output logic                 mac_first,
  output logic                 mac_last,
  output logic                 busy
);

  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic        [AW-1:0] tap_q,   tap_d;
  logic signed [DW-1:0] x_q [NTAPS];
  logic signed [DW-1:0] x_d [NTAPS];
  logic signed [CW-1:0] c_q [NTAPS];
  logic signed [CW-1:0] c_d [NTAPS];

`ifdef COEF_SHADOW_EN
  logic signed [CW-1:0] s_q [NTAPS];
  logic signed [CW-1:0] s_d [NTAPS];
  logic                 commit_pend_q, commit_pend_d;
`else
  logic                 unused_coef_commit;
  assign unused_coef_commit = coef_commit;
`endif

  logic last_tap;
  logic accept;
  logic addr_ok;

  // Handshake: ready when idle or on the final tap, so samples can stream back-to-back.
  always_comb begin
    last_tap = (tap_q == LAST_TAP);
    in_ready = (state_q == IDLE) || ((state_q == RUN) && last_tap);
    accept   = in_valid && in_ready;
    addr_ok  = (32'(coef_addr) < NTAPS);
  end

  // Next-state and tap counter: IDLE/RUN sequencing, one tap per clock.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          tap_d   = '0;
        end
      end
      RUN: begin
        if (last_tap) begin
          tap_d = '0;
          if (!accept) state_d = IDLE;
        end else begin
          tap_d = tap_q + AW'(1);
        end
      end
    endcase
  end

  // Delay line: shift only on accept, otherwise hold.
  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) x_d[i] = x_q[i];
    if (accept) begin
      x_d[0] = in_data;
      for (int unsigned i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
    end
  end

`ifdef COEF_SHADOW_EN
  // Coefficient banks: writes land in shadow; a pending commit copies shadow to
  // active only when idle or on an accept edge, so a sample never mixes banks.
  // The copy uses the registered shadow, so a write in the commit cycle is included.
  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) begin
      s_d[i] = s_q[i];
      c_d[i] = c_q[i];
    end
    commit_pend_d = commit_pend_q;
    if (commit_pend_q && ((state_q == IDLE) || accept)) begin
      for (int unsigned i = 0; i < NTAPS; i++) c_d[i] = s_q[i];
      commit_pend_d = 1'b0;
    end
    if (coef_we && addr_ok) s_d[coef_addr] = coef_wdata;
    if (coef_commit) commit_pend_d = 1'b1;
  end
`else
  // Coefficient bank: direct write; out-of-range addresses are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) c_d[i] = c_q[i];
    if (coef_we && addr_ok) c_d[coef_addr] = coef_wdata;
  end
`endif

  // MAC port: decoded purely from registered state.
  always_comb begin
    busy      = (state_q == RUN);
    mac_valid = busy;
    mac_data  = x_q[tap_q];
    mac_coef  = c_q[tap_q];
    mac_tap   = tap_q;
    mac_first = busy && (tap_q == '0);
    mac_last  = busy && last_tap;
  end

  // State, delay line and coefficient registers with async active-low reset.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
`ifdef COEF_SHADOW_EN
        s_q[i] <= '0;
`endif
      end
`ifdef COEF_SHADOW_EN
      commit_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_q[i] <= x_d[i];
        c_q[i] <= c_d[i];
`ifdef COEF_SHADOW_EN
        s_q[i] <= s_d[i];
`endif
      end
`ifdef COEF_SHADOW_EN
      commit_pend_q <= commit_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_folded_fir_scheduler.sv
// Self-checking bench for folded_fir_scheduler (NTAPS=5).
// A sample-level model (history of accepted samples, coefficient bank, cycles
// since last accept) is checked every cycle; directed tests add literal checks.
module tb_folded_fir_scheduler;

  localparam int NTAPS = 5;
  localparam int DW    = 12;
  localparam int CW    = 13;
  localparam int AW    = 3;

  logic                 clk100 = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 coef_we = 1'b0;
  logic        [AW-1:0] coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic                 coef_commit = 1'b0;
  logic                 mac_valid;
  logic signed [DW-1:0] mac_data;
  logic signed [CW-1:0] mac_coef;
  logic        [AW-1:0] mac_tap;
  logic                 mac_first;
  logic                 mac_last;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  folded_fir_scheduler #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk100     (clk100),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_commit(coef_commit),
    .mac_valid  (mac_valid),
    .mac_data   (mac_data),
    .mac_coef   (mac_coef),
    .mac_tap    (mac_tap),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .busy       (busy)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age = clock edges since the last accepted sample; a sample occupies the
  // MAC port for ages 0..NTAPS-1. hist[k] = k-th most recent accepted sample.
  int age = NTAPS;
  int hist[NTAPS];
  int coef[NTAPS];
  int shadow[NTAPS];
  bit pend = 1'b0;

  always @(posedge clk100 or negedge reset) begin
    bit acc, idle_before;
    int a;
    if (!reset) begin
      age  = NTAPS;
      pend = 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] = 0; coef[i] = 0; shadow[i] = 0;
      end
    end else begin
      idle_before = (age >= NTAPS);
      acc = in_valid && (age >= NTAPS - 1);
      a = int'(coef_addr);
`ifdef COEF_SHADOW_EN
      if (pend && (idle_before || acc)) begin
        for (int i = 0; i < NTAPS; i++) coef[i] = shadow[i];
        pend = 1'b0;
      end
      if (coef_we && a < NTAPS) shadow[a] = int'(coef_wdata);
      if (coef_commit) pend = 1'b1;
`else
      if (coef_we && a < NTAPS) coef[a] = int'(coef_wdata);
`endif
      if (acc) begin
        for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(in_data);
        age = 0;
      end else if (age < NTAPS) begin
        age = age + 1;
      end
    end
  end

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk100) begin
    if (!reset) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mac_valid", mac_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_first", mac_first, 0);
      chk("rst_last", mac_last, 0);
      chk("rst_data", int'(mac_data), 0);
      chk("rst_coef", int'(mac_coef), 0);
      chk("rst_tap", int'(mac_tap), 0);
    end else begin
      chk("m_in_ready", in_ready, int'(age >= NTAPS - 1));
      chk("m_mac_valid", mac_valid, int'(age < NTAPS));
      chk("m_busy", busy, int'(age < NTAPS));
      chk("m_first", mac_first, int'(age == 0));
      chk("m_last", mac_last, int'(age == NTAPS - 1));
      if (age < NTAPS) begin
        chk("m_tap", int'(mac_tap), age);
        chk("m_data", int'(mac_data), hist[age]);
        chk("m_coef", int'(mac_coef), coef[age]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int cap_d[NTAPS];
  int cap_c[NTAPS];
  int cap_t[NTAPS];
  int cap_f[NTAPS];
  int cap_l[NTAPS];
  int ed[NTAPS];
  int ec[NTAPS];

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = CW'(d);
    step();
    coef_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NTAPS; i++) wr(i, i + 1);
`ifdef COEF_SHADOW_EN
    coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
    step(); step();
`endif
  endtask

  // Called just after an accept edge: records the NTAPS MAC cycles.
  task automatic capture();
    for (int k = 0; k < NTAPS; k++) begin
      @(negedge clk100);
      cap_d[k] = int'(mac_data);
      cap_c[k] = int'(mac_coef);
      cap_t[k] = int'(mac_tap);
      cap_f[k] = int'(mac_first);
      cap_l[k] = int'(mac_last);
    end
  endtask

  task automatic check_cap(input string tag);
    for (int k = 0; k < NTAPS; k++) begin
      chk({tag, "_data"}, cap_d[k], ed[k]);
      chk({tag, "_coef"}, cap_c[k], ec[k]);
      chk({tag, "_tap"}, cap_t[k], k);
      chk({tag, "_first"}, cap_f[k], int'(k == 0));
      chk({tag, "_last"}, cap_l[k], int'(k == NTAPS - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int vcnt, rcnt;
    int s2[NTAPS];
    int s3[NTAPS];
    int ca[NTAPS];

    // Test 1: reset held then released; idle until first accept.
    repeat (3) step();
    @(negedge clk100);
    chk("t1_rst_ready", in_ready, 1);
    chk("t1_rst_valid", mac_valid, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk100);
      chk("t1_idle_valid", mac_valid, 0);
      chk("t1_idle_ready", in_ready, 1);
      chk("t1_idle_data", int'(mac_data), 0);
    end

    // Test 2: single sample from IDLE.
    step();
    load_ramp();
    in_valid = 1'b1; in_data = 12'sd100;
    step();
    in_valid = 1'b0;
    capture();
    ed = '{100, 0, 0, 0, 0};
    ec = '{1, 2, 3, 4, 5};
    check_cap("t2");
    @(negedge clk100);
    chk("t2_after_busy", busy, 0);
    chk("t2_after_valid", mac_valid, 0);

    // Test 3: in_valid held, samples 1,2,3 back-to-back.
    step();
    do_reset();
    load_ramp();
    vcnt = 0; rcnt = 0;
    in_valid = 1'b1; in_data = 12'sd1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) in_data = 12'sd2;
      if (i == 5) in_data = 12'sd3;
      if (i == 10) in_valid = 1'b0;
      @(negedge clk100);
      vcnt += int'(mac_valid);
      if (i < 15) rcnt += int'(in_ready);
      if (i >= 5 && i < 10) s2[i-5] = int'(mac_data);
      if (i >= 10 && i < 15) s3[i-10] = int'(mac_data);
    end
    chk("t3_valid_cycles", vcnt, 15);
    chk("t3_ready_cycles", rcnt, 3);
    ed = '{2, 1, 0, 0, 0};
    for (int k = 0; k < NTAPS; k++) chk("t3_s2_data", s2[k], ed[k]);
    ed = '{3, 2, 1, 0, 0};
    for (int k = 0; k < NTAPS; k++) chk("t3_s3_data", s3[k], ed[k]);

    // Test 4: reset asserted at tap 2 aborts the sample.
    step();
    do_reset();
    load_ramp();
    in_valid = 1'b1; in_data = 12'sd55;
    step();
    in_valid = 1'b0;
    step(); step();
    @(negedge clk100);
    chk("t4_pre_tap", int'(mac_tap), 2);
    #1 reset = 1'b0;
    #1;
    chk("t4_rst_valid", mac_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_last", mac_last, 0);
    chk("t4_rst_data", int'(mac_data), 0);
    chk("t4_rst_coef", int'(mac_coef), 0);
    chk("t4_rst_tap", int'(mac_tap), 0);
    chk("t4_rst_ready", in_ready, 1);
    step();
    reset = 1'b1;
    in_valid = 1'b1; in_data = 12'sd7;
    step();
    in_valid = 1'b0;
    capture();
    ed = '{7, 0, 0, 0, 0};
    ec = '{0, 0, 0, 0, 0};
    check_cap("t4");

`ifndef COEF_SHADOW_EN
    // Test 5: out-of-range write ignored; mid-sample write to a later tap is used.
    step();
    do_reset();
    load_ramp();
    wr(6, 77);
    in_valid = 1'b1; in_data = 12'sd11;
    step();
    in_valid = 1'b0;
    capture();
    ed = '{11, 0, 0, 0, 0};
    ec = '{1, 2, 3, 4, 5};
    check_cap("t5a");
    step();
    in_valid = 1'b1; in_data = -12'sd12;
    step();
    in_valid = 1'b0;
    step();
    wr(4, 9);
    repeat (2) @(negedge clk100);
    @(negedge clk100);
    chk("t5b_tap", int'(mac_tap), 4);
    chk("t5b_coef", int'(mac_coef), 9);
    chk("t5b_data", int'(mac_data), 0);
`else
    // Test 6: shadow commit mid-sample applies only from the next sample.
    step();
    do_reset();
    load_ramp();
    in_valid = 1'b1; in_data = 12'sd21;
    step();
    in_data = 12'sd22;
    @(negedge clk100); ca[0] = int'(mac_coef);
    step();
    @(negedge clk100); ca[1] = int'(mac_coef);
    step();
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = -13'sd4; coef_commit = 1'b1;
    @(negedge clk100); ca[2] = int'(mac_coef);
    step();
    coef_we = 1'b0; coef_commit = 1'b0;
    @(negedge clk100); ca[3] = int'(mac_coef);
    step();
    @(negedge clk100); ca[4] = int'(mac_coef);
    step();
    in_valid = 1'b0;
    ec = '{1, 2, 3, 4, 5};
    for (int k = 0; k < NTAPS; k++) chk("t6a_coef", ca[k], ec[k]);
    capture();
    ed = '{22, 21, 0, 0, 0};
    ec = '{-4, 2, 3, 4, 5};
    check_cap("t6b");
`endif

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
